rpn_sequencer: RTL and testbench
================================

# rpn_sequencer

Token-driven sequencer that sits directly upstream of the 8-bit hardware stack and drives its push/pop port. It accepts a stream of reverse-Polish tokens (operands and operators) over a valid/ready handshake. For each operand it pushes the value; for each operator it pops two values, computes the result, pushes it back and reports it. It keeps its own depth count, so stack overflow and underflow are flagged here rather than silently ignored by the stack.

## Interface
- `WIDTH`, 8, data width of tokens and stack entries
- `DEPTH`, 8, stack capacity in entries; must match the attached stack
- `clk` input 1: single clock, rising edge
- `reset_n` input 1: asynchronous active-low reset
- `tok_valid` input 1: token present on `tok_is_op`/`tok_data`
- `tok_ready` output 1: sequencer can accept a token this cycle
- `tok_is_op` input 1: 1 = operator token, 0 = operand token
- `tok_data` input WIDTH: operand value, or opcode in bits [1:0] (0 ADD, 1 SUB, 2 AND, 3 XOR)
- `stk_push` output 1: push request to stack
- `stk_pop` output 1: pop request to stack
- `stk_data_in` output WIDTH: value to push
- `stk_data_out` input WIDTH: popped value; valid the cycle after `stk_pop`
- `stk_empty` input 1: stack empty flag (monitored only; internal depth is authoritative)
- `res_valid` output 1: one-cycle pulse when an operator result is pushed
- `res_data` output WIDTH: last operator result; held until the next result
- `depth` output $clog2(DEPTH+1): current stack occupancy
- `err` output 1: sticky error (overflow or underflow); cleared only by reset

## Operation
- FSM states: IDLE, PUSH_NUM, POP_B, CAP_B, POP_A, CAP_A, PUSH_RES.
- `tok_ready` = 1 only in IDLE. A token is accepted on a rising edge with `tok_valid && tok_ready`.
- Operand with depth < DEPTH: IDLE→PUSH_NUM. `stk_push`=1 and `stk_data_in`=value for one cycle, then depth+1 and return to IDLE.
- Operand with depth == DEPTH (overflow): token consumed, `err` set, no stack traffic, stay IDLE.
- Operator with depth ≥ 2 runs the following sequence:
  - POP_B: `stk_pop`=1.
  - CAP_B: latch `stk_data_out` as B.
  - POP_A: `stk_pop`=1.
  - CAP_A: latch `stk_data_out` as A.
  - PUSH_RES: `stk_push`=1, `stk_data_in`=A op B, `res_valid`=1, `res_data` updated, depth−1.
  - Then return to IDLE.
- Operator with depth < 2 (underflow): token consumed, `err` set, no stack traffic, stay IDLE.
- Arithmetic is modulo 2^WIDTH; carries and borrows are discarded. SUB = A − B, where A is the deeper operand. Example: tokens 5, 3, SUB give 2.
- `stk_push` and `stk_pop` are never asserted in the same cycle. Each is asserted for exactly one cycle per request.
- Opcode bits above [1:0] are ignored.

## Timing
- All outputs are registered except `tok_ready`, which is decoded from state.
- Reset values: `stk_push`=0, `stk_pop`=0, `stk_data_in`=0, `res_valid`=0, `res_data`=0, `depth`=0, `err`=0, state=IDLE (so `tok_ready`=1). No token is accepted while `reset_n` is low.
- Operand latency: accepted at edge E0, `stk_push` high in the cycle after E0, `tok_ready` high again one cycle later. Throughput is 1 operand per 2 cycles.
- Operator latency: accepted at edge E0, then:
  - `stk_pop` in cycle 1 (POP_B) and cycle 3 (POP_A).
  - `stk_push` and `res_valid` in cycle 5.
  - `tok_ready` high in cycle 6.
- An error token takes one cycle; `tok_ready` stays high and `err` rises in the cycle after acceptance.
- Reset asserted mid-operation: immediate return to IDLE, depth=0, all pulses dropped, no partial result reported. The stack shares the reset, so occupancy stays consistent.
- `err` does not block operation. Later valid tokens are processed normally.

## Structure
- Package `rpn_pkg`: opcode localparams (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_XOR=3) and the FSM state enum.
- Sub-module `rpn_alu`: combinational, inputs A, B, opcode; output WIDTH-bit result.
- Top level `rpn_sequencer`: FSM, depth counter, operand latches, handshake.
- Test bench instantiates `rpn_sequencer` together with the stack, bridging the reset polarity.

## Test plan
- Tokens 5, 3, ADD → `res_valid` pulse with `res_data`=8, depth=1, `err`=0; popped value 8.
- Tokens 3, 5, SUB → `res_data`=0xFE (wrap); tokens 0xF0, 0x20, ADD → `res_data`=0x10.
- Push 8 operands, then a 9th operand → `err`=1, depth stays 8, no `stk_push` for the 9th; a following ADD still yields the correct sum of the top two.
- ADD with depth 1 → `err`=1, no `stk_pop` asserted, depth stays 1, `tok_ready` high the next cycle.
- `tok_valid` held high during an operator sequence → `tok_ready`=0 for cycles 1–5, next token accepted only in cycle 6; operator latency measured as exactly 5 cycles.
- Assert `reset_n` low during CAP_B → all outputs return to reset values, state IDLE; after release, tokens 1, 2, XOR → `res_data`=3.

Source files
------------

// File: rtl/rpn_sequencer_pkg.sv
// rpn_pkg: shared definitions for the RPN token sequencer.
//   - opcode encodings carried in tok_data[1:0] of an operator token
//   - FSM state enumeration used by rpn_sequencer
package rpn_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_NUM = 3'd1,
    POP_B    = 3'd2,
    CAP_B    = 3'd3,
    POP_A    = 3'd4,
    CAP_A    = 3'd5,
    PUSH_RES = 3'd6
  } state_e;

endpackage

// File: rtl/rpn_sequencer_if.sv
// rpn_sequencer_if: bundles the token handshake, the stack push/pop port and
// the result/status outputs of the sequencer.
//   master modport : token source + attached stack + observer (testbench side)
//   slave modport  : the sequencer itself
// Signals:
//   tok_valid/tok_ready/tok_is_op/tok_data : token valid/ready handshake
//   stk_push/stk_pop/stk_data_in           : requests towards the stack
//   stk_data_out/stk_empty                 : returned by the stack
//   res_valid/res_data/depth/err           : result and status
interface rpn_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             tok_valid;
  logic             tok_ready;
  logic             tok_is_op;
  logic [WIDTH-1:0] tok_data;
  logic             stk_push;
  logic             stk_pop;
  logic [WIDTH-1:0] stk_data_in;
  logic [WIDTH-1:0] stk_data_out;
  logic             stk_empty;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic [DW-1:0]    depth;
  logic             err;

  modport master (
    output tok_valid, tok_is_op, tok_data, stk_data_out, stk_empty,
    input  tok_ready, stk_push, stk_pop, stk_data_in,
           res_valid, res_data, depth, err
  );

  modport slave (
    input  tok_valid, tok_is_op, tok_data, stk_data_out, stk_empty,
    output tok_ready, stk_push, stk_pop, stk_data_in,
           res_valid, res_data, depth, err
  );

endinterface

// File: rtl/rpn_alu.sv
// rpn_alu: combinational operator unit.
//   a_i   : deeper operand (A)
//   b_i   : top-of-stack operand (B)
//   op_i  : opcode (ADD, SUB, AND, XOR)
//   res_o : A op B, modulo 2^WIDTH
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] res_o
);

  // Operator select; results truncate to WIDTH so carries/borrows drop.
  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: accepts reverse-Polish tokens and drives an external
// hardware stack. Operands are pushed; operators pop B then A, push A op B
// and report the result. Depth is tracked locally, so overflow/underflow
// tokens are consumed without stack traffic and raise a sticky err.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : rpn_sequencer_if slave (token handshake, stack port, status)
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           reset_n,
  rpn_sequencer_if.slave bus
);

  localparam int            DW      = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);
  localparam logic [DW-1:0] ONE_C   = DW'(1);
  localparam logic [DW-1:0] TWO_C   = DW'(2);

  state_e           state_q, state_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] alu_res;

  logic accept;
  logic num_ok;
  logic op_ok;
  logic tok_bad;

  assign accept  = bus.tok_valid && (state_q == IDLE);
  assign num_ok  = accept && !bus.tok_is_op && (depth_q < DEPTH_C);
  assign op_ok   = accept &&  bus.tok_is_op && (depth_q >= TWO_C);
  assign tok_bad = accept && !num_ok && !op_ok;

  // A is never held in its own register: in CAP_A the stack is presenting
  // A, so it feeds the ALU directly and the result lands in the push data.
  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i   (bus.stk_data_out),
    .b_i   (b_q),
    .op_i  (op_q),
    .res_o (alu_res)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (num_ok) begin
          state_d = PUSH_NUM;
        end else if (op_ok) begin
          state_d = POP_B;
        end else begin
          state_d = IDLE;
        end
      end
      PUSH_NUM: state_d = IDLE;
      POP_B:    state_d = CAP_B;
      CAP_B:    state_d = POP_A;
      POP_A:    state_d = CAP_A;
      CAP_A:    state_d = PUSH_RES;
      PUSH_RES: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output/datapath next values; pulses are set one edge early so the
  // registered copy lines up with the state that owns it.
  always_comb begin
    push_d      = 1'b0;
    pop_d       = 1'b0;
    res_valid_d = 1'b0;
    data_in_d   = data_in_q;
    res_data_d  = res_data_q;
    depth_d     = depth_q;
    b_d         = b_q;
    op_d        = op_q;
    err_d       = err_q | tok_bad;
    case (state_q)
      IDLE: begin
        if (num_ok) begin
          push_d    = 1'b1;
          data_in_d = bus.tok_data;
        end else if (op_ok) begin
          pop_d = 1'b1;
          op_d  = bus.tok_data[1:0];
        end else begin
          push_d = 1'b0;
        end
      end
      PUSH_NUM: depth_d = depth_q + ONE_C;
      POP_B:    pop_d   = 1'b0;
      CAP_B: begin
        b_d   = bus.stk_data_out;
        pop_d = 1'b1;
      end
      POP_A:    pop_d = 1'b0;
      CAP_A: begin
        push_d      = 1'b1;
        res_valid_d = 1'b1;
        data_in_d   = alu_res;
        res_data_d  = alu_res;
      end
      PUSH_RES: depth_d = depth_q - ONE_C;
      default:  depth_d = depth_q;
    endcase
  end

  // Registered outputs and operand/opcode latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      data_in_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      depth_q     <= '0;
      err_q       <= 1'b0;
      b_q         <= '0;
      op_q        <= 2'd0;
    end else begin
      push_q      <= push_d;
      pop_q       <= pop_d;
      data_in_q   <= data_in_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
      b_q         <= b_d;
      op_q        <= op_d;
    end
  end

  assign bus.tok_ready   = (state_q == IDLE);
  assign bus.stk_push    = push_q;
  assign bus.stk_pop     = pop_q;
  assign bus.stk_data_in = data_in_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.depth       = depth_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Testbench for rpn_sequencer with a behavioural 8-entry stack attached.
module tb_rpn_sequencer;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  rpn_sequencer_if #(.WIDTH(8), .DEPTH(8)) bus ();

  rpn_sequencer #(.WIDTH(8), .DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached stack: pop data appears the cycle after stk_pop.
  logic [7:0] mem [8];
  int         sp;
  logic [7:0] stk_dout;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp       <= 0;
      stk_dout <= 8'h00;
    end else if (bus.stk_push && sp < 8) begin
      mem[sp] <= bus.stk_data_in;
      sp      <= sp + 1;
    end else if (bus.stk_pop && sp > 0) begin
      stk_dout <= mem[sp-1];
      sp       <= sp - 1;
    end
  end
  assign bus.stk_data_out = stk_dout;
  assign bus.stk_empty    = (sp == 0);

  // Reference model: a queue as the stack plus sticky error and last result.
  logic [7:0] m_stk [$];
  logic       m_err;
  logic [7:0] m_res;

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op);
    case (op)
      2'd0:    return 8'((a + b) % 256);
      2'd1:    return 8'((a + 256 - b) % 256);
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic model_tok(input logic is_op, input logic [7:0] d,
                           output int ec, output int ep, output int epo,
                           output int er, output logic [7:0] epv);
    logic [7:0] a, b, r;
    ec = 0; ep = 0; epo = 0; er = 0; epv = 8'h00;
    if (!is_op) begin
      if (m_stk.size() < 8) begin
        m_stk.push_back(d);
        ec = 1; ep = 1; epv = d;
      end else begin
        m_err = 1'b1;
      end
    end else if (m_stk.size() < 2) begin
      m_err = 1'b1;
    end else begin
      b = m_stk.pop_back();
      a = m_stk.pop_back();
      r = ref_alu(a, b, d[1:0]);
      m_stk.push_back(r);
      m_res = r;
      ec = 5; ep = 1; epo = 2; er = 1; epv = r;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one token at a negedge, then observe until tok_ready returns.
  task automatic send(input logic is_op, input logic [7:0] d,
                      output int cyc, output int np, output int npo,
                      output int nr, output logic [7:0] pv);
    int w;
    w = 0;
    while (!bus.tok_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.tok_ready) chk("ready_wait_timeout", 32'd0, 32'd1);
    bus.tok_valid = 1'b1;
    bus.tok_is_op = is_op;
    bus.tok_data  = d;
    @(posedge clk);
    #1 bus.tok_valid = 1'b0;
    cyc = 0; np = 0; npo = 0; nr = 0; pv = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.stk_push) begin np++; pv = bus.stk_data_in; end
      if (bus.stk_pop) npo++;
      if (bus.res_valid) nr++;
      if (bus.tok_ready) break;
      cyc++;
    end
    if (!bus.tok_ready) chk("busy_timeout", 32'd0, 32'd1);
  endtask

  // Send a token and compare the DUT with the reference model.
  task automatic token(input string nm, input logic is_op, input logic [7:0] d);
    int cyc, np, npo, nr, ec, ep, epo, er;
    logic [7:0] pv, epv;
    send(is_op, d, cyc, np, npo, nr, pv);
    model_tok(is_op, d, ec, ep, epo, er, epv);
    chk({nm, "_cycles"}, cyc, ec);
    chk({nm, "_pushes"}, np, ep);
    chk({nm, "_pops"}, npo, epo);
    chk({nm, "_res_pulses"}, nr, er);
    if (ep > 0) chk({nm, "_push_value"}, pv, epv);
    chk({nm, "_depth"}, bus.depth, m_stk.size());
    chk({nm, "_err"}, bus.err, m_err);
    chk({nm, "_res_data"}, bus.res_data, m_res);
    chk({nm, "_stack_size"}, sp, m_stk.size());
    if (m_stk.size() > 0) chk({nm, "_stack_top"}, mem[sp-1], m_stk[$]);
  endtask

  typedef struct {
    logic       is_op;
    logic [7:0] data;
    logic [7:0] exp_res;
    int         exp_depth;
    logic       exp_err;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int busy;
    checks = 0; errors = 0;
    m_err = 1'b0; m_res = 8'h00;
    bus.tok_valid = 1'b1; bus.tok_is_op = 1'b0; bus.tok_data = 8'h55;
    reset_n = 1'b0;

    // Reset state, with a token offered that must not be taken.
    repeat (3) @(negedge clk);
    chk("rst_push", bus.stk_push, 1'b0);
    chk("rst_pop", bus.stk_pop, 1'b0);
    chk("rst_data_in", bus.stk_data_in, 8'h00);
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_data", bus.res_data, 8'h00);
    chk("rst_depth", bus.depth, 4'd0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_ready", bus.tok_ready, 1'b1);
    bus.tok_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_depth", bus.depth, 4'd0);

    // Directed vector table: {is_op, data, res_data, depth, err} after token.
    vecs.push_back('{1'b0, 8'h05, 8'h00, 1, 1'b0});
    vecs.push_back('{1'b0, 8'h03, 8'h00, 2, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 8'h08, 1, 1'b0});  // 5+3
    vecs.push_back('{1'b0, 8'h03, 8'h08, 2, 1'b0});
    vecs.push_back('{1'b0, 8'h05, 8'h08, 3, 1'b0});
    vecs.push_back('{1'b1, 8'h01, 8'hFE, 2, 1'b0});  // 3-5 wraps
    vecs.push_back('{1'b0, 8'hF0, 8'hFE, 3, 1'b0});
    vecs.push_back('{1'b0, 8'h20, 8'hFE, 4, 1'b0});
    vecs.push_back('{1'b1, 8'h00, 8'h10, 3, 1'b0});  // F0+20 wraps
    vecs.push_back('{1'b1, 8'h03, 8'hEE, 2, 1'b0});  // FE^10
    vecs.push_back('{1'b1, 8'h02, 8'h08, 1, 1'b0});  // 08&EE
    vecs.push_back('{1'b1, 8'h00, 8'h08, 1, 1'b1});  // underflow
    vecs.push_back('{1'b0, 8'h04, 8'h08, 2, 1'b1});
    vecs.push_back('{1'b1, 8'hFD, 8'h04, 1, 1'b1});  // upper bits ignored: SUB 8-4
    for (int k = 0; k < 7; k++) vecs.push_back('{1'b0, 8'(8'h11 + k), 8'h04, 2 + k, 1'b1});
    vecs.push_back('{1'b0, 8'h99, 8'h04, 8, 1'b1});  // overflow
    vecs.push_back('{1'b1, 8'h00, 8'h2D, 7, 1'b1});  // 16+17

    for (int i = 0; i < vecs.size(); i++) begin
      token($sformatf("vec%0d", i), vecs[i].is_op, vecs[i].data);
      chk($sformatf("vec%0d_tbl_res", i), bus.res_data, vecs[i].exp_res);
      chk($sformatf("vec%0d_tbl_depth", i), bus.depth, vecs[i].exp_depth);
      chk($sformatf("vec%0d_tbl_err", i), bus.err, vecs[i].exp_err);
    end

    // tok_valid held through an operator: next token taken only in cycle 6.
    begin
      int ec, ep, epo, er;
      logic [7:0] epv;
      bus.tok_valid = 1'b1; bus.tok_is_op = 1'b1; bus.tok_data = 8'h00;
      @(posedge clk);
      #1 bus.tok_is_op = 1'b0; bus.tok_data = 8'h07;
      busy = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.tok_ready) break;
        busy++;
      end
      chk("held_busy_cycles", busy, 5);
      model_tok(1'b1, 8'h00, ec, ep, epo, er, epv);
      chk("held_res_data", bus.res_data, m_res);
      @(posedge clk);
      #1 bus.tok_valid = 1'b0;
      @(negedge clk);
      chk("held_next_push", bus.stk_push, 1'b1);
      chk("held_next_value", bus.stk_data_in, 8'h07);
      model_tok(1'b0, 8'h07, ec, ep, epo, er, epv);
      @(negedge clk);
      chk("held_depth", bus.depth, m_stk.size());
    end

    // Reset during CAP_B, then 1,2,XOR from a clean state.
    bus.tok_valid = 1'b1; bus.tok_is_op = 1'b1; bus.tok_data = 8'h00;
    @(posedge clk);
    #1 bus.tok_valid = 1'b0;
    @(negedge clk);
    chk("midrst_pop_b", bus.stk_pop, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_push", bus.stk_push, 1'b0);
    chk("midrst_pop", bus.stk_pop, 1'b0);
    chk("midrst_data_in", bus.stk_data_in, 8'h00);
    chk("midrst_res_valid", bus.res_valid, 1'b0);
    chk("midrst_res_data", bus.res_data, 8'h00);
    chk("midrst_depth", bus.depth, 4'd0);
    chk("midrst_err", bus.err, 1'b0);
    chk("midrst_ready", bus.tok_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    m_stk.delete(); m_err = 1'b0; m_res = 8'h00;
    token("xr1", 1'b0, 8'h01);
    token("xr2", 1'b0, 8'h02);
    token("xr_xor", 1'b1, 8'h03);
    chk("xr_res_is_3", bus.res_data, 8'h03);

    // Randomised token stream against the model.
    for (int i = 0; i < 300; i++) begin
      token($sformatf("rnd%0d", i), ($urandom_range(0, 9) < 4), 8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
